// File: rtl/eater_control.sv
// Microcode sequencer for the SAP-style 8-bit CPU: walks T0..T4 per instruction
// and decodes (step, opcode, flags) into the datapath control word.
module eater_control #(
   parameter int STEPS = 5,
   parameter int OPW   = 4
) (
   input  logic           clk,
   input  logic           clear_n,
   input  logic           run,
   input  logic [OPW-1:0] opcode,
   input  logic [1:0]     flags,
   output logic [2:0]     step,
   output logic           halted,
   output logic           pc_out,
   output logic           pc_inc,
   output logic           jump,
   output logic           mar_in,
   output logic           ram_in,
   output logic           ram_out,
   output logic           ir_in,
   output logic           ir_out,
   output logic           a_in,
   output logic           a_out,
   output logic           b_in,
   output logic           sum_out,
   output logic           subtract,
   output logic           flags_load,
   output logic           out_in
);

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_LDA = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_STA = 4'b0100,
      OP_LDI = 4'b0101,
      OP_JMP = 4'b0110,
      OP_JC  = 4'b0111,
      OP_JZ  = 4'b1000,
      OP_OUT = 4'b1110,
      OP_HLT = 4'b1111
   } opcode_t;

   typedef struct packed {
      logic pc_out;
      logic pc_inc;
      logic jump;
      logic mar_in;
      logic ram_in;
      logic ram_out;
      logic ir_in;
      logic ir_out;
      logic a_in;
      logic a_out;
      logic b_in;
      logic sum_out;
      logic subtract;
      logic flags_load;
      logic out_in;
   } ctrl_t;

   localparam step_t LAST_STEP = step_t'(STEPS - 1);

   step_t   step_q;
   logic    halted_q;
   logic [3:0] op;
   ctrl_t   word;
   ctrl_t   ctrl;
   logic    last_step;
   logic    active;

   assign op     = opcode[3:0];
   assign active = clear_n && run && !halted_q;

   // Raw microcode word for the current step, plus whether this step is the
   // final non-empty one so the counter can wrap early.
   always_comb begin
      word      = '0;
      last_step = 1'b0;
      case (step_q)
         T0: begin
            word.pc_out = 1'b1;
            word.mar_in = 1'b1;
         end
         T1: begin
            word.ram_out = 1'b1;
            word.ir_in   = 1'b1;
            word.pc_inc  = 1'b1;
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
               OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 1'b0;
               default:                              last_step = 1'b1;
            endcase
         end
         T2: begin
            last_step = 1'b1;
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  word.ir_out = 1'b1;
                  word.mar_in = 1'b1;
                  last_step   = 1'b0;
               end
               OP_LDI: begin
                  word.ir_out = 1'b1;
                  word.a_in   = 1'b1;
               end
               OP_JMP: begin
                  word.ir_out = 1'b1;
                  word.jump   = 1'b1;
               end
               OP_JC: begin
                  word.ir_out = flags[1];
                  word.jump   = flags[1];
               end
               OP_JZ: begin
                  word.ir_out = flags[0];
                  word.jump   = flags[0];
               end
               OP_OUT: begin
                  word.a_out  = 1'b1;
                  word.out_in = 1'b1;
               end
               default: ;
            endcase
         end
         T3: begin
            last_step = 1'b1;
            case (op)
               OP_LDA: begin
                  word.ram_out = 1'b1;
                  word.a_in    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  word.ram_out = 1'b1;
                  word.b_in    = 1'b1;
                  last_step    = 1'b0;
               end
               OP_STA: begin
                  word.a_out  = 1'b1;
                  word.ram_in = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            last_step = 1'b1;
            if (op == OP_ADD || op == OP_SUB) begin
               word.sum_out    = 1'b1;
               word.a_in       = 1'b1;
               word.flags_load = 1'b1;
               word.subtract   = (op == OP_SUB);
            end
         end
         default: last_step = 1'b1;
      endcase
      if (step_q >= LAST_STEP) begin
         last_step = 1'b1;
      end
   end

   // HLT freezes the counter at T2 instead of wrapping; only clear_n releases it.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else if (run && !halted_q) begin
         if (step_q == T2 && op == OP_HLT) begin
            halted_q <= 1'b1;
         end else if (last_step) begin
            step_q <= T0;
         end else begin
            step_q <= step_t'(step_q + 3'd1);
         end
      end
   end

   assign ctrl = active ? word : '0;

   assign step       = step_q;
   assign halted     = halted_q;
   assign pc_out     = ctrl.pc_out;
   assign pc_inc     = ctrl.pc_inc;
   assign jump       = ctrl.jump;
   assign mar_in     = ctrl.mar_in;
   assign ram_in     = ctrl.ram_in;
   assign ram_out    = ctrl.ram_out;
   assign ir_in      = ctrl.ir_in;
   assign ir_out     = ctrl.ir_out;
   assign a_in       = ctrl.a_in;
   assign a_out      = ctrl.a_out;
   assign b_in       = ctrl.b_in;
   assign sum_out    = ctrl.sum_out;
   assign subtract   = ctrl.subtract;
   assign flags_load = ctrl.flags_load;
   assign out_in     = ctrl.out_in;

endmodule

// File: tb/tb_eater_control.sv
// Directed bench for eater_control: fetch/execute words, jumps, halt, pause,
// async clear and a per-opcode sweep against a hand-written microcode table.
module tb_eater_control;

   localparam logic [14:0] CO = 15'd1 << 14;
   localparam logic [14:0] CE = 15'd1 << 13;
   localparam logic [14:0] J  = 15'd1 << 12;
   localparam logic [14:0] MI = 15'd1 << 11;
   localparam logic [14:0] RI = 15'd1 << 10;
   localparam logic [14:0] RO = 15'd1 << 9;
   localparam logic [14:0] II = 15'd1 << 8;
   localparam logic [14:0] IO = 15'd1 << 7;
   localparam logic [14:0] AI = 15'd1 << 6;
   localparam logic [14:0] AO = 15'd1 << 5;
   localparam logic [14:0] BI = 15'd1 << 4;
   localparam logic [14:0] EO = 15'd1 << 3;
   localparam logic [14:0] SU = 15'd1 << 2;
   localparam logic [14:0] FI = 15'd1 << 1;
   localparam logic [14:0] OI = 15'd1 << 0;

   logic       clk;
   logic       clear_n;
   logic       run;
   logic [3:0] opcode;
   logic [1:0] flags;
   logic [2:0] step;
   logic       halted;
   logic       pc_out, pc_inc, jump, mar_in, ram_in, ram_out, ir_in, ir_out;
   logic       a_in, a_out, b_in, sum_out, subtract, flags_load, out_in;
   logic [14:0] ctrl;

   int total = 0;
   int bad   = 0;

   eater_control #(.STEPS(5), .OPW(4)) dut (
      .clk(clk), .clear_n(clear_n), .run(run), .opcode(opcode), .flags(flags),
      .step(step), .halted(halted),
      .pc_out(pc_out), .pc_inc(pc_inc), .jump(jump), .mar_in(mar_in),
      .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
      .a_in(a_in), .a_out(a_out), .b_in(b_in), .sum_out(sum_out),
      .subtract(subtract), .flags_load(flags_load), .out_in(out_in)
   );

   assign ctrl = {pc_out, pc_inc, jump, mar_in, ram_in, ram_out, ir_in, ir_out,
                  a_in, a_out, b_in, sum_out, subtract, flags_load, out_in};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Expected microcode word for opcode/step with both flags set (jumps taken).
   function automatic logic [14:0] expWord(input int op, input int s);
      logic [14:0] w;
      w = '0;
      if (s == 0) w = CO | MI;
      else if (s == 1) w = RO | II | CE;
      else if (s == 2) begin
         case (op)
            1, 2, 3, 4: w = IO | MI;
            5:          w = IO | AI;
            6, 7, 8:    w = IO | J;
            14:         w = AO | OI;
            default:    w = '0;
         endcase
      end else if (s == 3) begin
         case (op)
            1:       w = RO | AI;
            2, 3:    w = RO | BI;
            4:       w = AO | RI;
            default: w = '0;
         endcase
      end else if (s == 4) begin
         case (op)
            2:       w = EO | AI | FI;
            3:       w = EO | SU | AI | FI;
            default: w = '0;
         endcase
      end
      return w;
   endfunction

   function automatic int expLen(input int op);
      case (op)
         1, 4:             return 4;
         2, 3:             return 5;
         5, 6, 7, 8, 14:   return 3;
         default:          return 2;
      endcase
   endfunction

   // At most one bus driver may be active in any state.
   always @(negedge clk) begin
      checkOutput("bus_onehot",
                  16'($countones({pc_out, ram_out, ir_out, a_out, sum_out}) <= 1), 16'd1);
   end

   initial begin
      clear_n = 1'b0;
      run     = 1'b1;
      opcode  = 4'b0000;
      flags   = 2'b00;
      #3;
      checkOutput("reset_step", 16'(step), 16'd0);
      checkOutput("reset_halted", 16'(halted), 16'd0);
      checkOutput("reset_ctrl", 16'(ctrl), 16'd0);
      #9 clear_n = 1'b1;
      #1;
      checkOutput("nop_t0_word", 16'(ctrl), 16'(CO | MI));
      applyStimulus(1);
      checkOutput("nop_step1", 16'(step), 16'd1);
      checkOutput("nop_t1_word", 16'(ctrl), 16'(RO | II | CE));
      applyStimulus(1);
      checkOutput("nop_step0", 16'(step), 16'd0);
      applyStimulus(1);
      checkOutput("nop_step1b", 16'(step), 16'd1);
      applyStimulus(1);
      checkOutput("nop_step0b", 16'(step), 16'd0);

      opcode = 4'b0011;
      applyStimulus(2);
      checkOutput("sub_t2_word", 16'(ctrl), 16'(IO | MI));
      applyStimulus(1);
      checkOutput("sub_t3_word", 16'(ctrl), 16'(RO | BI));
      applyStimulus(1);
      checkOutput("sub_step4", 16'(step), 16'd4);
      checkOutput("sub_t4_word", 16'(ctrl), 16'(EO | SU | AI | FI));
      applyStimulus(1);
      checkOutput("sub_wrap", 16'(step), 16'd0);

      opcode = 4'b0111;
      flags  = 2'b10;
      applyStimulus(2);
      checkOutput("jc_taken_word", 16'(ctrl), 16'(IO | J));
      applyStimulus(1);
      checkOutput("jc_taken_wrap", 16'(step), 16'd0);
      flags = 2'b00;
      applyStimulus(2);
      checkOutput("jc_untaken_step", 16'(step), 16'd2);
      checkOutput("jc_untaken_word", 16'(ctrl), 16'd0);
      applyStimulus(1);
      checkOutput("jc_untaken_wrap", 16'(step), 16'd0);
      opcode = 4'b1000;
      flags  = 2'b01;
      applyStimulus(2);
      checkOutput("jz_taken_word", 16'(ctrl), 16'(IO | J));
      applyStimulus(1);
      flags = 2'b10;
      applyStimulus(2);
      checkOutput("jz_untaken_word", 16'(ctrl), 16'd0);
      applyStimulus(1);
      checkOutput("jz_untaken_wrap", 16'(step), 16'd0);

      opcode = 4'b1111;
      applyStimulus(2);
      checkOutput("hlt_t2_word", 16'(ctrl), 16'd0);
      checkOutput("hlt_t2_not_yet", 16'(halted), 16'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1);
         checkOutput("hlt_halted", 16'(halted), 16'd1);
         checkOutput("hlt_step_frozen", 16'(step), 16'd2);
         checkOutput("hlt_ctrl_zero", 16'(ctrl), 16'd0);
      end
      #2 clear_n = 1'b0;
      #1;
      checkOutput("clear_step", 16'(step), 16'd0);
      checkOutput("clear_halted", 16'(halted), 16'd0);
      checkOutput("clear_ctrl", 16'(ctrl), 16'd0);
      #1 clear_n = 1'b1;
      opcode = 4'b0001;
      #1;
      checkOutput("clear_t0_word", 16'(ctrl), 16'(CO | MI));

      applyStimulus(3);
      checkOutput("lda_t3_word", 16'(ctrl), 16'(RO | AI));
      run = 1'b0;
      #1;
      checkOutput("pause_ctrl", 16'(ctrl), 16'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("pause_step", 16'(step), 16'd3);
         checkOutput("pause_ctrl_hold", 16'(ctrl), 16'd0);
      end
      run = 1'b1;
      #1;
      checkOutput("resume_word", 16'(ctrl), 16'(RO | AI));
      applyStimulus(1);
      checkOutput("resume_wrap", 16'(step), 16'd0);

      flags = 2'b11;
      for (int op = 0; op < 15; op++) begin
         opcode = 4'(op);
         for (int s = 0; s < expLen(op); s++) begin
            #1;
            checkOutput($sformatf("sweep_step_op%0d_t%0d", op, s), 16'(step), 16'(s));
            checkOutput($sformatf("sweep_word_op%0d_t%0d", op, s), 16'(ctrl),
                        16'(expWord(op, s)));
            applyStimulus(1);
         end
         checkOutput($sformatf("sweep_wrap_op%0d", op), 16'(step), 16'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
